// File: rtl/axi_bram2stream_master_if.sv
// AXI4-Stream handshake bundle between the BRAM streamer (master) and its sink (slave).
interface axi_bram2stream_master_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0]   S_AXIS_TDATA;
    logic [DATA_W/8-1:0] S_AXIS_TSTRB;
    logic                S_AXIS_TLAST;
    logic                S_AXIS_TVALID;
    logic                S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA,
        output S_AXIS_TSTRB,
        output S_AXIS_TLAST,
        output S_AXIS_TVALID,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA,
        input  S_AXIS_TSTRB,
        input  S_AXIS_TLAST,
        input  S_AXIS_TVALID,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/axi_bram2stream_master.sv
// Streams words 0..SRC_ADDR_MAX-1 of a fixed 2-cycle-latency source memory out of an AXI4-Stream master,
// with a 4-deep FWFT FIFO absorbing backpressure and a sticky done flag after the TLAST beat.
module axi_bram2stream_master #(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned SRC_ADDR_WIDTH       = 12,
    parameter int unsigned SRC_ADDR_MAX         = 1024
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    axi_bram2stream_master_if.master        axis,
    output logic [SRC_ADDR_WIDTH-1:0]       src_addr,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] src_data,
    input  logic                            src_ready,
    output logic                            src_enable,
    output logic                            done
);
    localparam int unsigned CNT_W      = SRC_ADDR_WIDTH + 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned OCC_W      = 3;

    logic [CNT_W-1:0]                rd_cnt;
    logic [CNT_W-1:0]                beat_cnt;
    logic [1:0]                      inflight;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [OCC_W-1:0]                occ;
    logic [OCC_W-1:0]                pending;
    logic                            issue;
    logic                            push;
    logic                            pop;
    logic                            tvalid;
    logic                            tlast;

    // Issue only while the FIFO is guaranteed room for everything already requested.
    always_comb begin
        tvalid  = (occ != '0);
        tlast   = tvalid && (beat_cnt == CNT_W'(SRC_ADDR_MAX - 1));
        push    = inflight[1];
        pop     = tvalid && axis.S_AXIS_TREADY;
        pending = occ + OCC_W'(inflight[0]) + OCC_W'(inflight[1]);
        issue   = S_AXIS_ARESETN && src_ready && !done
                  && (rd_cnt < CNT_W'(SRC_ADDR_MAX))
                  && (pending < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            done     <= 1'b0;
        end else begin
            // inflight[1] marks the cycle in which src_data carries a requested word
            inflight <= {inflight[0], issue};
            if (issue) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (pop && tlast) begin
                done <= 1'b1;
            end
        end
    end

    // FIFO storage, cleared on reset so TDATA reads zero while in reset.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= src_data;
        end
    end

    assign src_addr           = rd_cnt[SRC_ADDR_WIDTH-1:0];
    assign src_enable         = issue;
    assign axis.S_AXIS_TDATA  = fifo_mem[rd_ptr];
    assign axis.S_AXIS_TSTRB  = '1;
    assign axis.S_AXIS_TLAST  = tlast;
    assign axis.S_AXIS_TVALID = tvalid;
endmodule

// File: tb/tb_axi_bram2stream_master.sv
// Bench for axi_bram2stream_master: a 2-cycle-latency memory model feeds the DUT and every accepted
// beat is checked against the expected word sequence under several TREADY/src_ready patterns.
module tb_axi_bram2stream_master;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 12;
    localparam int unsigned MAX = 1024;

    logic          tb_clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          src_enable;
    logic          done;

    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_data;
    logic          s1_enable;
    logic          s1_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 tb_clk = ~tb_clk;

    axi_bram2stream_master_if #(.DATA_W(DW)) ax0 ();
    axi_bram2stream_master_if #(.DATA_W(DW)) ax1 ();

    axi_bram2stream_master #(
        .C_S_AXIS_TDATA_WIDTH(DW), .SRC_ADDR_WIDTH(AW), .SRC_ADDR_MAX(MAX)
    ) u_dut (
        .S_AXIS_ACLK(tb_clk), .S_AXIS_ARESETN(rst_n), .axis(ax0),
        .src_addr(src_addr), .src_data(src_data), .src_ready(src_ready),
        .src_enable(src_enable), .done(done)
    );

    // Single-word instance for the SRC_ADDR_MAX=1 corner
    axi_bram2stream_master #(
        .C_S_AXIS_TDATA_WIDTH(DW), .SRC_ADDR_WIDTH(AW), .SRC_ADDR_MAX(1)
    ) u_dut1 (
        .S_AXIS_ACLK(tb_clk), .S_AXIS_ARESETN(rst_n), .axis(ax1),
        .src_addr(s1_addr), .src_data(s1_data), .src_ready(src_ready),
        .src_enable(s1_enable), .done(s1_done)
    );

    function automatic logic [DW-1:0] mem_word(input int a);
        return 32'hA000_0000 + DW'(a);
    endfunction

    // Source memory: data for a read issued in cycle k is visible only during cycle k+2
    logic [AW:0] p1, p2, q1, q2;
    always @(posedge tb_clk) begin
        p1 <= {src_enable, src_addr};
        p2 <= p1;
        q1 <= {s1_enable, s1_addr};
        q2 <= q1;
    end
    always_comb src_data = p2[AW] ? mem_word(int'(p2[AW-1:0])) : 32'hDEAD_BEEF;
    always_comb s1_data  = q2[AW] ? mem_word(int'(q2[AW-1:0])) : 32'hDEAD_BEEF;

    task automatic test_reset();
        rst_n = 1'b0;
        src_ready = 1'b1;
        ax0.S_AXIS_TREADY = 1'b1;
        ax1.S_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge tb_clk);
        #1;
        n_vec++; if (ax0.S_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", ax0.S_AXIS_TVALID); end
        n_vec++; if (ax0.S_AXIS_TLAST !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b want 0", ax0.S_AXIS_TLAST); end
        n_vec++; if (src_enable !== 1'b0) begin n_err++; $display("FAIL reset_src_enable: got %b want 0", src_enable); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (ax0.S_AXIS_TDATA !== '0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", ax0.S_AXIS_TDATA); end
        n_vec++; if (src_addr !== '0) begin n_err++; $display("FAIL reset_src_addr: got %h want 0", src_addr); end
        n_vec++; if (ax0.S_AXIS_TSTRB !== 4'hF) begin n_err++; $display("FAIL reset_tstrb: got %h want f", ax0.S_AXIS_TSTRB); end
    endtask

    // Runs one transfer from reset release; mode picks the TREADY/src_ready pattern.
    // mode 0: all ready, 1: TREADY toggles, 2: random, 3: TREADY low 20 cycles, 4: src_ready low 10 cycles
    task automatic run_transfer(input int mode, input int abort_at,
                                output int beats, output int first_valid, output int last_cyc);
        int          issued;
        bit          finished;
        logic        prev_stall;
        logic        prev_last;
        logic [DW-1:0] prev_data;
        int          budget;
        issued = 0; beats = 0; first_valid = -1; last_cyc = -1; finished = 0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        budget = 6 * int'(MAX) + 200;
        rst_n = 1'b0;
        src_ready = 1'b0;
        ax0.S_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge tb_clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (abort_at > 0 && beats == abort_at) begin
                rst_n = 1'b0;
                #1;
                n_vec++; if (ax0.S_AXIS_TVALID !== 1'b0 || ax0.S_AXIS_TLAST !== 1'b0) begin n_err++; $display("FAIL abort_stream_clear: got tvalid=%b tlast=%b want 0 0", ax0.S_AXIS_TVALID, ax0.S_AXIS_TLAST); end
                n_vec++; if (src_enable !== 1'b0 || src_addr !== '0) begin n_err++; $display("FAIL abort_src_clear: got en=%b addr=%h want 0 0", src_enable, src_addr); end
                n_vec++; if (done !== 1'b0 || ax0.S_AXIS_TDATA !== '0) begin n_err++; $display("FAIL abort_done_data: got done=%b tdata=%h want 0 0", done, ax0.S_AXIS_TDATA); end
                return;
            end
            case (mode)
                1: begin ax0.S_AXIS_TREADY = 1'((cyc % 2) == 1); src_ready = 1'b1; end
                2: begin ax0.S_AXIS_TREADY = 1'($urandom % 2); src_ready = 1'(($urandom % 5) != 0); end
                3: begin ax0.S_AXIS_TREADY = 1'(!(cyc >= 300 && cyc < 320)); src_ready = 1'b1; end
                4: begin ax0.S_AXIS_TREADY = 1'b1; src_ready = 1'(!(cyc >= 200 && cyc < 210)); end
                default: begin ax0.S_AXIS_TREADY = 1'b1; src_ready = 1'b1; end
            endcase
            #1;
            n_vec++; if (ax0.S_AXIS_TSTRB !== 4'hF) begin n_err++; $display("FAIL tstrb c%0d: got %h want f", cyc, ax0.S_AXIS_TSTRB); end
            if (!src_ready) begin
                n_vec++; if (src_enable !== 1'b0) begin n_err++; $display("FAIL read_while_not_ready c%0d: got en=%b want 0", cyc, src_enable); end
            end
            if (src_enable === 1'b1) begin
                n_vec++; if (src_addr !== AW'(issued)) begin n_err++; $display("FAIL src_addr c%0d: got %h want %h", cyc, src_addr, AW'(issued)); end
                n_vec++; if (issued >= int'(MAX)) begin n_err++; $display("FAIL extra_read c%0d: got read #%0d want < %0d", cyc, issued, MAX); end
                issued++;
            end
            n_vec++; if (issued - beats > 4) begin n_err++; $display("FAIL outstanding c%0d: got %0d want <= 4", cyc, issued - beats); end
            if (prev_stall) begin
                n_vec++; if (ax0.S_AXIS_TVALID !== 1'b1 || ax0.S_AXIS_TDATA !== prev_data || ax0.S_AXIS_TLAST !== prev_last)
                    begin n_err++; $display("FAIL stall_hold c%0d: got v=%b d=%h l=%b want 1 %h %b", cyc, ax0.S_AXIS_TVALID, ax0.S_AXIS_TDATA, ax0.S_AXIS_TLAST, prev_data, prev_last); end
            end
            if (ax0.S_AXIS_TVALID === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                n_vec++; if (ax0.S_AXIS_TDATA !== mem_word(beats)) begin n_err++; $display("FAIL tdata c%0d: got %h want %h", cyc, ax0.S_AXIS_TDATA, mem_word(beats)); end
                n_vec++; if (ax0.S_AXIS_TLAST !== 1'(beats == int'(MAX) - 1)) begin n_err++; $display("FAIL tlast c%0d beat %0d: got %b want %b", cyc, beats, ax0.S_AXIS_TLAST, beats == int'(MAX) - 1); end
            end else begin
                n_vec++; if (ax0.S_AXIS_TLAST !== 1'b0) begin n_err++; $display("FAIL tlast_idle c%0d: got %b want 0", cyc, ax0.S_AXIS_TLAST); end
            end
            n_vec++; if (done !== 1'(last_cyc >= 0)) begin n_err++; $display("FAIL done c%0d: got %b want %b", cyc, done, last_cyc >= 0); end
            if (last_cyc >= 0) begin
                n_vec++; if (ax0.S_AXIS_TVALID !== 1'b0 || src_enable !== 1'b0) begin n_err++; $display("FAIL after_done c%0d: got v=%b en=%b want 0 0", cyc, ax0.S_AXIS_TVALID, src_enable); end
            end
            if (mode == 3 && cyc == 319) begin
                n_vec++; if (issued - beats != 4 || ax0.S_AXIS_TVALID !== 1'b1) begin n_err++; $display("FAIL stall_fill: got outstanding=%0d v=%b want 4 1", issued - beats, ax0.S_AXIS_TVALID); end
            end
            if (mode == 4 && cyc == 209) begin
                n_vec++; if (ax0.S_AXIS_TVALID !== 1'b0) begin n_err++; $display("FAIL src_gap_drain: got v=%b want 0", ax0.S_AXIS_TVALID); end
            end
            prev_stall = ax0.S_AXIS_TVALID && !ax0.S_AXIS_TREADY;
            prev_data  = ax0.S_AXIS_TDATA;
            prev_last  = ax0.S_AXIS_TLAST;
            if (ax0.S_AXIS_TVALID === 1'b1 && ax0.S_AXIS_TREADY === 1'b1) begin
                if (ax0.S_AXIS_TLAST === 1'b1) last_cyc = cyc;
                beats++;
            end
            if (last_cyc >= 0 && cyc >= last_cyc + 4) begin
                finished = 1;
                break;
            end
            @(negedge tb_clk);
        end
        n_vec++; if (!finished) begin n_err++; $display("FAIL timeout mode %0d: got %0d beats without done, want %0d", mode, beats, MAX); end
    endtask

    task automatic test_full_rate();
        int b, fv, lc;
        run_transfer(0, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX)) begin n_err++; $display("FAIL full_beats: got %0d want %0d", b, MAX); end
        n_vec++; if (fv != 3) begin n_err++; $display("FAIL first_tvalid_cycle: got %0d want 3", fv); end
        n_vec++; if (lc != int'(MAX) + 2) begin n_err++; $display("FAIL last_beat_cycle: got %0d want %0d", lc, MAX + 2); end
    endtask

    task automatic test_backpressure();
        int b, fv, lc;
        run_transfer(1, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX)) begin n_err++; $display("FAIL toggle_beats: got %0d want %0d", b, MAX); end
        run_transfer(2, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX)) begin n_err++; $display("FAIL random_beats: got %0d want %0d", b, MAX); end
    endtask

    task automatic test_stall_window();
        int b, fv, lc;
        run_transfer(3, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX)) begin n_err++; $display("FAIL stall_beats: got %0d want %0d", b, MAX); end
    endtask

    task automatic test_src_gap();
        int b, fv, lc;
        run_transfer(4, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX)) begin n_err++; $display("FAIL src_gap_beats: got %0d want %0d", b, MAX); end
    endtask

    task automatic test_reset_mid();
        int b, fv, lc;
        run_transfer(0, 500, b, fv, lc);
        n_vec++; if (b != 500) begin n_err++; $display("FAIL abort_beats: got %0d want 500", b); end
        run_transfer(0, 0, b, fv, lc);
        n_vec++; if (b != int'(MAX) || fv != 3) begin n_err++; $display("FAIL restart: got beats=%0d first=%0d want %0d 3", b, fv, MAX); end
    endtask

    task automatic test_single_word();
        rst_n = 1'b0;
        src_ready = 1'b1;
        ax1.S_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge tb_clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            n_vec++; if (s1_enable !== 1'(cyc == 0)) begin n_err++; $display("FAIL one_enable c%0d: got %b want %b", cyc, s1_enable, cyc == 0); end
            if (cyc == 0) begin
                n_vec++; if (s1_addr !== '0) begin n_err++; $display("FAIL one_addr: got %h want 0", s1_addr); end
            end
            n_vec++; if (ax1.S_AXIS_TVALID !== 1'(cyc == 3)) begin n_err++; $display("FAIL one_tvalid c%0d: got %b want %b", cyc, ax1.S_AXIS_TVALID, cyc == 3); end
            if (cyc == 3) begin
                n_vec++; if (ax1.S_AXIS_TDATA !== mem_word(0) || ax1.S_AXIS_TLAST !== 1'b1) begin n_err++; $display("FAIL one_beat: got d=%h l=%b want %h 1", ax1.S_AXIS_TDATA, ax1.S_AXIS_TLAST, mem_word(0)); end
            end
            n_vec++; if (s1_done !== 1'(cyc >= 4)) begin n_err++; $display("FAIL one_done c%0d: got %b want %b", cyc, s1_done, cyc >= 4); end
            @(negedge tb_clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        src_ready = 1'b0;
        ax0.S_AXIS_TREADY = 1'b0;
        ax1.S_AXIS_TREADY = 1'b0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_stall_window();
        test_src_gap();
        test_reset_mid();
        test_single_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
